// File: rtl/alu_result_stage.sv
// Registered output stage behind the 64-bit ALU: 2-entry result FIFO with Z/N/V flags,
// a sticky overflow flag and a wrapping count of delivered results.
module alu_result_stage #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_ov,
   input  logic [1:0]        op_sel,
   input  logic              b_inv,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [2:0]        out_op,
   output logic              out_z,
   output logic              out_n,
   output logic              out_v,
   output logic              sticky_ov,
   input  logic              sticky_clr,
   output logic [CNT_W-1:0]  result_cnt
);

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic              b_inv;
      logic [1:0]        op_sel;
      logic              z;
      logic              n;
      logic              v;
   } entry_t;

   entry_t             mem_q [2];
   entry_t             mem_d [2];
   entry_t             head_q, head_d;
   entry_t             new_entry;
   logic               wr_ptr_q, wr_ptr_d;
   logic               rd_ptr_q, rd_ptr_d;
   logic [1:0]         count_q, count_d;
   logic               sticky_q, sticky_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               push, pop;

   assign in_ready  = ~count_q[1];
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      new_entry        = '0;
      new_entry.result = alu_out;
      new_entry.b_inv  = b_inv;
      new_entry.op_sel = op_sel;
      new_entry.z      = (alu_out == '0);
      new_entry.n      = alu_out[DATA_W-1];
      // Overflow only has meaning for add/sub.
      new_entry.v      = (op_sel == 2'b00) & alu_ov;
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = new_entry;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      if (pop) begin
         cnt_d = cnt_q + 1'b1;
      end
      // Set takes priority over clear.
      if (push && new_entry.v) begin
         sticky_d = 1'b1;
      end else if (sticky_clr) begin
         sticky_d = 1'b0;
      end
      // Output register tracks the next head; holds its last value once empty.
      head_d = head_q;
      if (count_d != 2'd0) begin
         head_d = mem_d[rd_ptr_d];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         head_q   <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         head_q   <= head_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_result = head_q.result;
   assign out_op     = {head_q.b_inv, head_q.op_sel};
   assign out_z      = head_q.z;
   assign out_n      = head_q.n;
   assign out_v      = head_q.v;
   assign sticky_ov  = sticky_q;
   assign result_cnt = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: vector table for flag derivation plus
// hand-written sequences for backpressure, streaming, sticky, reset and counter wrap.
module tb_alu_result_stage;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] alu_out;
   logic              alu_ov;
   logic [1:0]        op_sel;
   logic              b_inv;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [2:0]        out_op;
   logic              out_z;
   logic              out_n;
   logic              out_v;
   logic              sticky_ov;
   logic              sticky_clr;
   logic [CNT_W-1:0]  result_cnt;

   int n_cmp = 0;
   int n_err = 0;
   logic [CNT_W-1:0] exp_cnt;
   logic             exp_sticky;

   alu_result_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_out    (alu_out),
      .alu_ov     (alu_ov),
      .op_sel     (op_sel),
      .b_inv      (b_inv),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_op     (out_op),
      .out_z      (out_z),
      .out_n      (out_n),
      .out_v      (out_v),
      .sticky_ov  (sticky_ov),
      .sticky_clr (sticky_clr),
      .result_cnt (result_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic        ov;
      logic [1:0]  sel;
      logic        binv;
      logic        z;
      logic        n;
      logic        v;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push one entry from empty with out_ready high, then let it drain.
   task automatic push_drain(input logic [63:0] d);
      alu_out  = d;
      alu_ov   = 1'b0;
      op_sel   = 2'b01;
      b_inv    = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      exp_cnt = exp_cnt + 1'b1;
   endtask

   initial begin
      vecs[0] = '{64'h0000_0000_0000_0005, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{64'h0000_0000_0000_0000, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{64'h8000_0000_0000_0000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{64'h0000_0000_0000_0000, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      alu_out    = '0;
      alu_ov     = 1'b0;
      op_sel     = 2'b00;
      b_inv      = 1'b0;
      out_ready  = 1'b0;
      sticky_clr = 1'b0;
      exp_cnt    = '0;
      exp_sticky = 1'b0;
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_out_op", 64'(out_op), 64'd0);
      chk("rst_flags", 64'({out_z, out_n, out_v}), 64'd0);
      chk("rst_sticky", 64'(sticky_ov), 64'd0);
      chk("rst_cnt", 64'(result_cnt), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Flag derivation, one entry at a time with 1-cycle latency.
      for (int i = 0; i < 6; i++) begin
         alu_out   = vecs[i].data;
         alu_ov    = vecs[i].ov;
         op_sel    = vecs[i].sel;
         b_inv     = vecs[i].binv;
         in_valid  = 1'b1;
         out_ready = 1'b1;
         tick();
         exp_sticky = exp_sticky | vecs[i].v;
         chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("vec%0d_result", i), out_result, vecs[i].data);
         chk($sformatf("vec%0d_op", i), 64'(out_op), 64'({vecs[i].binv, vecs[i].sel}));
         chk($sformatf("vec%0d_zn_v", i), 64'({out_z, out_n, out_v}),
             64'({vecs[i].z, vecs[i].n, vecs[i].v}));
         chk($sformatf("vec%0d_sticky", i), 64'(sticky_ov), 64'(exp_sticky));
         in_valid = 1'b0;
         tick();
         exp_cnt = exp_cnt + 1'b1;
         chk($sformatf("vec%0d_drained", i), 64'(out_valid), 64'd0);
         chk($sformatf("vec%0d_cnt", i), 64'(result_cnt), 64'(exp_cnt));
      end

      // Clear sticky alone.
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      chk("sticky_clr", 64'(sticky_ov), 64'd0);

      // Backpressure: fill both entries, full input ignored, then drain in order.
      out_ready = 1'b0;
      alu_out   = 64'h8000_0000_0000_0000;
      alu_ov    = 1'b1;
      op_sel    = 2'b00;
      b_inv     = 1'b0;
      in_valid  = 1'b1;
      tick();
      chk("bp_in_ready_1", 64'(in_ready), 64'd1);
      chk("bp_head_nv", 64'({out_n, out_v}), 64'b11);
      alu_out = 64'h0;
      op_sel  = 2'b11;
      tick();
      chk("bp_in_ready_full", 64'(in_ready), 64'd0);
      alu_out = 64'h123;
      op_sel  = 2'b00;
      tick();
      chk("bp_full_hold_head", out_result, 64'h8000_0000_0000_0000);
      chk("bp_full_in_ready", 64'(in_ready), 64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      exp_cnt = exp_cnt + 1'b1;
      chk("bp_second_result", out_result, 64'h0);
      chk("bp_second_zv", 64'({out_z, out_v}), 64'b10);
      chk("bp_second_op", 64'(out_op), 64'b011);
      chk("bp_second_valid", 64'(out_valid), 64'd1);
      tick();
      exp_cnt = exp_cnt + 1'b1;
      chk("bp_empty", 64'(out_valid), 64'd0);
      chk("bp_sticky", 64'(sticky_ov), 64'd1);
      chk("bp_cnt", 64'(result_cnt), 64'(exp_cnt));

      // Streaming at count 1.
      out_ready = 1'b0;
      alu_out   = 64'd100;
      alu_ov    = 1'b0;
      op_sel    = 2'b01;
      in_valid  = 1'b1;
      tick();
      for (int i = 1; i <= 10; i++) begin
         alu_out   = 64'(i);
         out_ready = 1'b1;
         tick();
         exp_cnt = exp_cnt + 1'b1;
         chk($sformatf("stream%0d_result", i), out_result, 64'(i));
         chk($sformatf("stream%0d_ready", i), 64'({in_ready, out_valid}), 64'b11);
      end
      in_valid = 1'b0;
      tick();
      exp_cnt = exp_cnt + 1'b1;
      chk("stream_empty", 64'(out_valid), 64'd0);
      chk("stream_cnt", 64'(result_cnt), 64'(exp_cnt));

      // Sticky set and clear in the same cycle: set wins.
      sticky_clr = 1'b1;
      alu_out    = 64'd7;
      alu_ov     = 1'b1;
      op_sel     = 2'b00;
      in_valid   = 1'b1;
      tick();
      chk("sticky_set_wins", 64'(sticky_ov), 64'd1);
      in_valid = 1'b0;
      tick();
      exp_cnt    = exp_cnt + 1'b1;
      sticky_clr = 1'b0;
      chk("sticky_clr_alone", 64'(sticky_ov), 64'd0);

      // Reset mid-operation with two entries held.
      out_ready = 1'b0;
      alu_out   = 64'd11;
      alu_ov    = 1'b1;
      op_sel    = 2'b00;
      in_valid  = 1'b1;
      tick();
      alu_out = 64'd22;
      tick();
      in_valid = 1'b0;
      chk("mid_full", 64'({out_valid, in_ready, sticky_ov}), 64'b101);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_cnt", 64'(result_cnt), 64'd0);
      chk("mid_rst_sticky", 64'(sticky_ov), 64'd0);
      chk("mid_rst_result", out_result, 64'd0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      tick();
      exp_cnt = '0;
      chk("post_mid_no_stale", 64'(out_valid), 64'd0);
      chk("post_mid_cnt", 64'(result_cnt), 64'd0);

      // Counter wrap at CNT_W=4.
      for (int i = 0; i < 15; i++) begin
         push_drain(64'(i + 1));
      end
      chk("cnt_all_ones", 64'(result_cnt), 64'hF);
      push_drain(64'd99);
      chk("cnt_wrap", 64'(result_cnt), 64'(exp_cnt));
      chk("cnt_wrap_zero", 64'(result_cnt), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
